// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
//   UART-side control block in front of the MIPS pipeline. It decodes the
//   received byte stream into program loads and run/step commands, writes
//   program words into instruction memory, gates the pipeline clock-enable and
//   reports the PC (and optionally an enabled-cycle count) over the UART
//   transmitter.
//
//   Commands received in IDLE:
//     'L' (8'h4C)  load: next byte N = word count (0 means 256), then 4*N bytes,
//                  each word big-endian (first byte is the MSB)
//     'C' (8'h43)  run until the pipeline reports halt, then report
//     'S' (8'h53)  single step, then report
//
// Ports
//   clk, reset   system clock, asynchronous active-high reset
//   rx_done      1-cycle strobe, rx_data valid
//   rx_data      received byte
//   tx_done      1-cycle strobe, transmitter finished the last byte
//   tx_start     1-cycle strobe, send tx_data
//   tx_data      byte to transmit
//   halt         pipeline retired HALT
//   pc_value     current pipeline PC
//   mips_enable  pipeline clock-enable
//   mips_reset   pipeline reset request (held from reset until the first
//                command byte, held while waiting for the load length, and
//                pulsed for one cycle after a load completes)
//   imem_wr_en   instruction memory write strobe
//   imem_addr    instruction memory word address
//   imem_data    instruction memory write word
//
// Configuration
//   DEBUG_UNIT_CYCLE_COUNT_EN  when defined, a 32-bit counter of enabled
//   pipeline cycles is kept (cleared by a completed load) and each report is
//   8 bytes: PC then count, both MSB first. Otherwise reports are 4 PC bytes.
// -----------------------------------------------------------------------------
module debug_unit #(
    parameter int LEN        = 32,
    parameter int NB_DATA    = 8,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    input  logic               halt,
    input  logic [LEN-1:0]     pc_value,
    output logic               mips_enable,
    output logic               mips_reset,
    output logic               imem_wr_en,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [LEN-1:0]     imem_data
);

    localparam int BYTES_PER_WORD = LEN / NB_DATA;
    localparam int CNT_W          = NB_DATA + 1;
    localparam int BCNT_W         = 4;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int CYC_W          = 32;
    localparam int TX_BYTES       = BYTES_PER_WORD + CYC_W / NB_DATA;
`else
    localparam int TX_BYTES       = BYTES_PER_WORD;
`endif
    localparam int REPORT_W       = TX_BYTES * NB_DATA;

    localparam logic [NB_DATA-1:0] CMD_LOAD = NB_DATA'(8'h4C);
    localparam logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(8'h43);
    localparam logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(8'h53);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LEN,
        LOAD_BYTES,
        WRITE,
        RUN,
        STEP,
        SEND,
        WAIT_TX
    } state_t;

    state_t state, state_next;

    logic [LEN-1:0]    word_sr;
    logic [BCNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_total;
    logic              boot_hold;
    logic              load_pulse;
    logic              rx_ok;
    logic              last_word;
    logic              last_byte;
    logic [REPORT_W-1:0] report;

    // A transmitter completion wins over a coincident received byte.
    assign rx_ok     = rx_done & ~tx_done;
    assign last_word = (word_cnt + CNT_W'(1)) == word_total;
    assign last_byte = byte_cnt == BCNT_W'(BYTES_PER_WORD - 1);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cycle_cnt;
    assign report = {pc_value, cycle_cnt};
`else
    assign report = pc_value;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mips_enable = 1'b0;
        tx_start    = 1'b0;
        imem_wr_en  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ok) begin
                    if (rx_data == CMD_LOAD) begin
                        state_next = LOAD_LEN;
                    end else if (rx_data == CMD_RUN) begin
                        state_next = RUN;
                    end else if (rx_data == CMD_STEP) begin
                        state_next = STEP;
                    end
                end
            end
            LOAD_LEN: begin
                if (rx_ok) begin
                    state_next = LOAD_BYTES;
                end
            end
            LOAD_BYTES: begin
                if (rx_ok && last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                imem_wr_en = 1'b1;
                state_next = last_word ? IDLE : LOAD_BYTES;
            end
            RUN: begin
                // halt gates the enable in the same cycle it is seen
                if (halt) begin
                    state_next = SEND;
                end else begin
                    mips_enable = 1'b1;
                end
            end
            STEP: begin
                mips_enable = ~halt;
                state_next  = SEND;
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_next = (byte_cnt == BCNT_W'(TX_BYTES - 1)) ? IDLE : SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Report byte selection: byte_cnt counts bytes already sent, MSB first.
    always_comb begin
        tx_data = '0;
        if (state == SEND || state == WAIT_TX) begin
            for (int i = 0; i < TX_BYTES; i++) begin
                if (byte_cnt == BCNT_W'(i)) begin
                    tx_data = report[(TX_BYTES - 1 - i) * NB_DATA +: NB_DATA];
                end
            end
        end
    end

    assign mips_reset = boot_hold | load_pulse | (state == LOAD_LEN);
    assign imem_addr  = ADDR_W'(word_cnt);
    assign imem_data  = word_sr;

    // Datapath: word assembly, load/report counters and the reset-request flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_sr    <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_total <= '0;
            boot_hold  <= 1'b1;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ok) begin
                        boot_hold <= 1'b0;
                    end
                end
                LOAD_LEN: begin
                    if (rx_ok) begin
                        word_total <= (rx_data == '0) ? {1'b1, {NB_DATA{1'b0}}}
                                                      : {1'b0, rx_data};
                        word_cnt   <= '0;
                        byte_cnt   <= '0;
                    end
                end
                LOAD_BYTES: begin
                    if (rx_ok) begin
                        word_sr  <= {word_sr[LEN-NB_DATA-1:0], rx_data};
                        byte_cnt <= last_byte ? '0 : byte_cnt + BCNT_W'(1);
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    if (last_word) begin
                        load_pulse <= 1'b1;
                    end
                end
                RUN, STEP: begin
                    byte_cnt <= '0;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    // Enabled-cycle counter, restarted whenever a new program finishes loading.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (state == WRITE && last_word) begin
            cycle_cnt <= '0;
        end else if (mips_enable) begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_debug_unit
//   Self-checking bench for debug_unit. A UART transmitter stand-in answers
//   every tx_start with a tx_done after a random gap; a monitor records memory
//   writes, transmitted bytes and enable activity. Expected values come from a
//   simple model of the command protocol (program words, PC/cycle reports).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debug_unit;

    localparam int ADDR_W = 8;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int REPORT_BYTES = 8;
`else
    localparam int REPORT_BYTES = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc_value = 32'h0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mips_enable;
    logic        mips_reset;
    logic        imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_data;

    int total = 0;
    int bad = 0;
    int tx_gap = 1;
    int unsigned model_cycles = 0;

    logic [7:0]        tx_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int   en_cycles = 0;
    int   en_pulses = 0;
    logic en_prev = 1'b0;
    int   rst_after_wr = 0;
    int   tx_overlap = 0;
    logic tx_busy = 1'b0;

    debug_unit dut (
        .clk        (clk),
        .reset      (reset),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .halt       (halt),
        .pc_value   (pc_value),
        .mips_enable(mips_enable),
        .mips_reset (mips_reset),
        .imem_wr_en (imem_wr_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data)
    );

    always #5 clk = ~clk;

    // Monitor: samples late in the low phase, just before the capturing edge.
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            if (imem_wr_en === 1'b1) begin
                wr_addr_q.push_back(imem_addr);
                wr_data_q.push_back(imem_data);
                rst_after_wr = 0;
            end else if (mips_reset === 1'b1) begin
                rst_after_wr++;
            end
            if (tx_done === 1'b1) tx_busy = 1'b0;
            if (tx_start === 1'b1) begin
                if (tx_busy) tx_overlap++;
                tx_q.push_back(tx_data);
                tx_busy = 1'b1;
            end
            if (mips_enable === 1'b1) en_cycles++;
            if (mips_enable === 1'b1 && en_prev !== 1'b1) en_pulses++;
            en_prev = mips_enable;
        end
    end

    // Transmitter stand-in: one tx_done per tx_start, tx_gap cycles later.
    initial begin
        @(negedge clk);
        forever begin
            #4;
            if (tx_start === 1'b1 && !reset) begin
                @(negedge clk);
                repeat (tx_gap) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    function automatic void clear_monitor();
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        en_cycles    = 0;
        en_pulses    = 0;
        rst_after_wr = 0;
        tx_overlap   = 0;
        tx_busy      = 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic load_program(input logic [31:0] words[$]);
        send_byte(8'h4C);
        send_byte(8'(words.size()));
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                send_byte(words[i][8*b +: 8]);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_report(output bit ok);
        int cyc = 0;
        while ((tx_q.size() < REPORT_BYTES || tx_busy) && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        ok = (cyc < 600);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (mips_reset !== 1'b1) begin bad++; $display("[TB] FAIL reset_mips_reset got %b want 1", mips_reset); end
        total++; if (mips_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_mips_enable got %b want 0", mips_enable); end
        total++; if ({tx_start, tx_data} !== 9'h0) begin bad++; $display("[TB] FAIL reset_tx got %h want 000", {tx_start, tx_data}); end
        total++; if ({imem_wr_en, imem_addr, imem_data} !== 41'h0) begin bad++; $display("[TB] FAIL reset_imem got %h want 0", {imem_wr_en, imem_addr, imem_data}); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        total++; if (mips_reset !== 1'b1) begin bad++; $display("[TB] FAIL boot_hold got %b want 1", mips_reset); end
        clear_monitor();
        model_cycles = 0;
    endtask

    task automatic test_load();
        logic [31:0] prog[$];
        int errs;
        clear_monitor();
        prog = '{32'h00000001, 32'hFC000000};
        load_program(prog);
        model_cycles = 0;
        total++; if (wr_addr_q.size() !== 2) begin bad++; $display("[TB] FAIL load_count got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() == 2) begin
            total++; if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h00000001) begin bad++; $display("[TB] FAIL load_word0 got %h:%h want 00:00000001", wr_addr_q[0], wr_data_q[0]); end
            total++; if (wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'hFC000000) begin bad++; $display("[TB] FAIL load_word1 got %h:%h want 01:fc000000", wr_addr_q[1], wr_data_q[1]); end
        end
        total++; if (rst_after_wr !== 1) begin bad++; $display("[TB] FAIL load_reset_pulse got %0d cycles want 1", rst_after_wr); end

        clear_monitor();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back($urandom);
        load_program(prog);
        errs = 0;
        for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== prog[i]) errs++;
        end
        total++; if (wr_addr_q.size() !== 5 || errs != 0) begin bad++; $display("[TB] FAIL load_random got %0d writes %0d wrong want 5 writes 0 wrong", wr_addr_q.size(), errs); end
        total++; if (rst_after_wr !== 1) begin bad++; $display("[TB] FAIL load_random_pulse got %0d want 1", rst_after_wr); end
    endtask

    task automatic test_run(input int n_en, input logic [31:0] pc);
        int cnt = 0;
        int cyc = 0;
        bit ok;
        logic [63:0] expv;
        clear_monitor();
        tx_gap = int'($urandom_range(0, 3));
        pc_value = pc;
        halt = 1'b0;
        send_byte(8'h43);
        while (cnt < n_en && cyc < 200) begin
            #4;
            if (mips_enable === 1'b1) cnt++;
            cyc++;
            @(negedge clk);
        end
        total++; if (cnt != n_en) begin bad++; $display("[TB] FAIL run_enable_timeout got %0d want %0d", cnt, n_en); end
        halt = 1'b1;
        #4;
        total++; if (mips_enable !== 1'b0) begin bad++; $display("[TB] FAIL run_halt_gate got %b want 0", mips_enable); end
        model_cycles += n_en;
        wait_report(ok);
        halt = 1'b0;
        total++; if (!ok) begin bad++; $display("[TB] FAIL run_report_timeout got %0d bytes want %0d", tx_q.size(), REPORT_BYTES); end
        total++; if (en_cycles != n_en) begin bad++; $display("[TB] FAIL run_enable_cycles got %0d want %0d", en_cycles, n_en); end
        expv = {pc, model_cycles};
        for (int i = 0; i < REPORT_BYTES && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== expv[63-8*i -: 8]) begin bad++; $display("[TB] FAIL run_byte%0d got %h want %h", i, tx_q[i], expv[63-8*i -: 8]); end
        end
    endtask

    task automatic test_step();
        bit ok;
        logic [31:0] pc;
        logic [63:0] expv;
        for (int k = 0; k < 4; k++) begin
            clear_monitor();
            tx_gap = int'($urandom_range(0, 3));
            pc = $urandom;
            pc_value = pc;
            halt = (k == 3);
            send_byte(8'h53);
            wait_report(ok);
            if (k < 3) model_cycles += 1;
            total++; if (!ok) begin bad++; $display("[TB] FAIL step%0d_timeout got %0d bytes", k, tx_q.size()); end
            total++; if (en_cycles != ((k < 3) ? 1 : 0) || en_pulses != ((k < 3) ? 1 : 0)) begin bad++; $display("[TB] FAIL step%0d_enable got %0d cycles want %0d", k, en_cycles, (k < 3) ? 1 : 0); end
            total++; if (tx_q.size() != REPORT_BYTES) begin bad++; $display("[TB] FAIL step%0d_bytes got %0d want %0d", k, tx_q.size(), REPORT_BYTES); end
            expv = {pc, model_cycles};
            for (int i = 0; i < REPORT_BYTES && i < tx_q.size(); i++) begin
                total++; if (tx_q[i] !== expv[63-8*i -: 8]) begin bad++; $display("[TB] FAIL step%0d_byte%0d got %h want %h", k, i, tx_q[i], expv[63-8*i -: 8]); end
            end
        end
        halt = 1'b0;
    endtask

    task automatic test_robust();
        bit ok;
        int cyc = 0;
        logic [31:0] pc;
        logic [63:0] expv;
        clear_monitor();
        send_byte(8'h7A);
        repeat (20) @(negedge clk);
        total++; if (wr_addr_q.size() + tx_q.size() + en_cycles != 0) begin bad++; $display("[TB] FAIL ignore_7a got wr=%0d tx=%0d en=%0d want 0", wr_addr_q.size(), tx_q.size(), en_cycles); end

        clear_monitor();
        tx_gap = 6;
        pc = $urandom;
        pc_value = pc;
        send_byte(8'h53);
        while (tx_q.size() < 1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        send_byte(8'h53);
        wait_report(ok);
        model_cycles += 1;
        repeat (30) @(negedge clk);
        total++; if (!ok) begin bad++; $display("[TB] FAIL drop_timeout got %0d bytes", tx_q.size()); end
        total++; if (en_cycles != 1) begin bad++; $display("[TB] FAIL drop_enable got %0d want 1", en_cycles); end
        total++; if (tx_q.size() != REPORT_BYTES) begin bad++; $display("[TB] FAIL drop_bytes got %0d want %0d", tx_q.size(), REPORT_BYTES); end
        total++; if (tx_overlap != 0) begin bad++; $display("[TB] FAIL tx_overlap got %0d want 0", tx_overlap); end
        expv = {pc, model_cycles};
        for (int i = 0; i < REPORT_BYTES && i < tx_q.size(); i++) begin
            total++; if (tx_q[i] !== expv[63-8*i -: 8]) begin bad++; $display("[TB] FAIL drop_byte%0d got %h want %h", i, tx_q[i], expv[63-8*i -: 8]); end
        end
        tx_gap = 1;
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] prog[$];
        clear_monitor();
        send_byte(8'h4C);
        send_byte(8'h03);
        send_byte(8'hA5);
        send_byte(8'h5A);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++; if (mips_reset !== 1'b1 || mips_enable !== 1'b0 || tx_start !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ctrl got rst=%b en=%b tx=%b want 1 0 0", mips_reset, mips_enable, tx_start); end
        total++; if (imem_wr_en !== 1'b0 || imem_addr !== 8'd0 || imem_data !== 32'h0) begin bad++; $display("[TB] FAIL midreset_imem got %b %h %h want 0 00 00000000", imem_wr_en, imem_addr, imem_data); end
        @(negedge clk);
        reset = 1'b0;
        model_cycles = 0;
        clear_monitor();
        prog = '{$urandom};
        load_program(prog);
        total++; if (wr_addr_q.size() != 1) begin bad++; $display("[TB] FAIL reload_count got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            total++; if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== prog[0]) begin bad++; $display("[TB] FAIL reload_word got %h:%h want 00:%h", wr_addr_q[0], wr_data_q[0], prog[0]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] prog[$];
        int errs = 0;
        clear_monitor();
        for (int i = 0; i < 256; i++) prog.push_back($urandom);
        load_program(prog);
        model_cycles = 0;
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== prog[i]) errs++;
        end
        total++; if (wr_addr_q.size() != 256 || errs != 0) begin bad++; $display("[TB] FAIL wrap_words got %0d writes %0d wrong want 256 0", wr_addr_q.size(), errs); end
        if (wr_addr_q.size() > 0) begin
            total++; if (wr_addr_q[wr_addr_q.size()-1] !== 8'd255) begin bad++; $display("[TB] FAIL wrap_last_addr got %0d want 255", wr_addr_q[wr_addr_q.size()-1]); end
        end
        total++; if (rst_after_wr !== 1) begin bad++; $display("[TB] FAIL wrap_reset_pulse got %0d want 1", rst_after_wr); end
    endtask

    initial begin
        $display("[TB] debug_unit bench, report length %0d bytes", REPORT_BYTES);
        test_reset();
        test_load();
        test_run(10, 32'h00000028);
        test_step();
        test_robust();
        test_reset_mid_load();
        test_wrap();
        test_run(int'($urandom_range(3, 20)), $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
